// File: rtl/keypad_entry.sv
// Keypad password entry front-end.
// Collects decimal digits from the keypad scanner and accumulates them into a binary value.
// A full-length ENTER publishes that value on password_out. Also handles CLEAR, BACKSPACE,
// an idle timeout and lockout while the door alarm is active.
module keypad_entry #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned WIDTH          = 14,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic             lock_in,
    output logic [WIDTH-1:0] password_out,
    output logic             password_valid,
    output logic [2:0]       digit_count,
    output logic             entry_error
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // The largest DIGITS-digit value must fit in WIDTH bits, so acc*10+d cannot overflow.
    localparam bit WidthOk = (WIDTH >= 64) || ((pow10(DIGITS) - 1) < (64'd1 << WIDTH));

    generate
        if (DIGITS < 1 || DIGITS > 7) begin : g_bad_digits
            $error("keypad_entry: DIGITS must be in 1..7 (digit_count is 3 bits)");
        end
        if (WIDTH < 4) begin : g_bad_width_min
            $error("keypad_entry: WIDTH must be at least 4");
        end
        if (!WidthOk) begin : g_bad_width
            $error("keypad_entry: WIDTH too small for DIGITS decimal digits");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("keypad_entry: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int unsigned TimerW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]        CntFull   = 3'(DIGITS);
    localparam logic [WIDTH-1:0]  Ten       = WIDTH'(10);

    localparam logic [3:0] KeyClear = 4'hA;
    localparam logic [3:0] KeyEnter = 4'hB;
    localparam logic [3:0] KeyBksp  = 4'hC;

    typedef enum logic [0:0] {
        StIdle,
        StEntry
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [2:0]        count_q, count_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [WIDTH-1:0]  pw_q, pw_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    // ------------------------------------------------------------------
    // Key decode
    // ------------------------------------------------------------------
    logic is_digit;
    logic key_live;

    // Codes D-F are treated as if no key was pressed at all.
    assign is_digit = (key_code <= 4'd9);
    assign key_live = key_valid && !lock_in && (key_code <= KeyBksp);

    // Next-state logic: entry FSM, accumulator, timeout and output pulses.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        timer_d = timer_q;
        pw_d    = pw_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (lock_in) begin
            // Alarm active: silently drop any partial entry.
            state_d = StIdle;
            acc_d   = '0;
            count_d = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    timer_d = '0;
                    if (key_live && is_digit) begin
                        acc_d   = WIDTH'(key_code);
                        count_d = 3'd1;
                        state_d = StEntry;
                    end
                end

                StEntry: begin
                    if (key_live) begin
                        // Any processed key restarts the idle timer and pre-empts a timeout.
                        timer_d = '0;
                        if (is_digit) begin
                            if (count_q == CntFull) begin
                                err_d = 1'b1;
                            end else begin
                                acc_d   = (acc_q * Ten) + WIDTH'(key_code);
                                count_d = count_q + 3'd1;
                            end
                        end else begin
                            case (key_code)
                                KeyBksp: begin
                                    acc_d   = acc_q / Ten;
                                    count_d = count_q - 3'd1;
                                    if (count_q == 3'd1) begin
                                        state_d = StIdle;
                                    end
                                end
                                KeyClear: begin
                                    acc_d   = '0;
                                    count_d = '0;
                                    state_d = StIdle;
                                end
                                KeyEnter: begin
                                    if (count_q == CntFull) begin
                                        pw_d    = acc_q;
                                        valid_d = 1'b1;
                                    end else begin
                                        err_d = 1'b1;
                                    end
                                    acc_d   = '0;
                                    count_d = '0;
                                    state_d = StIdle;
                                end
                                default: ;
                            endcase
                        end
                    end else if (timer_q == TimerLast) begin
                        acc_d   = '0;
                        count_d = '0;
                        timer_d = '0;
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end

                default: begin
                    state_d = StIdle;
                    acc_d   = '0;
                    count_d = '0;
                    timer_d = '0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            count_q <= '0;
            timer_q <= '0;
            pw_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            timer_q <= timer_d;
            pw_q    <= pw_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign password_out   = pw_q;
    assign password_valid = valid_q;
    assign digit_count    = count_q;
    assign entry_error    = err_q;

endmodule
